// File: rtl/psram_word_bridge_pkg.sv
// Shared constants for the PSRAM word bridge: FSM encoding and byte-lane helpers.
package psram_bridge_pkg;

    // FSM encoding, kept as plain constants so older tooling can read it.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_MERGE   = 3'd3;
    localparam logic [2:0] ST_WR_WAIT = 3'd4;
    localparam logic [2:0] ST_WR      = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_ERR     = 3'd7;

    // Byte-lane geometry.
    localparam int LANE_W        = 8;
    localparam int DEFAULT_BYTES = 4;

    // Width of a byte index within a word; a one-byte word still gets one bit.
    function automatic int idx_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

    localparam int IDX_W = idx_width(DEFAULT_BYTES);

endpackage

// File: rtl/psram_word_bridge_rise_detect.sv
// Registered rising-edge detector. The history register resets high so a level
// that is already asserted when reset releases does not produce an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic rise
);

    logic lvl_q;

    // Remember the previous level; reset high to mask levels present at reset.
    always_ff @(posedge clk) begin
        if (rst) lvl_q <= 1'b1;
        else     lvl_q <= lvl;
    end

    assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/psram_word_bridge.sv
// Word-to-byte bridge in front of the PSRAM byte controller. Two requesters
// (port 1 has priority) issue word reads/writes; partial-strobe writes are done
// as read-modify-write. A stalled mem_ready raises a sticky error interrupt.
module psram_word_bridge
    import psram_bridge_pkg::*;
#(
    parameter  int ADDR_WIDTH = 22,
    parameter  int BYTES      = 4,
    parameter  int TIMEOUT    = 4096,
    localparam int DATA_WIDTH = LANE_W * BYTES,
    localparam int BIDX_W     = idx_width(BYTES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         p0_req,
    input  logic                         p0_we,
    input  logic [ADDR_WIDTH-1:0]        p0_addr,
    input  logic [DATA_WIDTH-1:0]        p0_wdata,
    input  logic [BYTES-1:0]             p0_wstrb,
    output logic                         p0_ack,
    output logic [DATA_WIDTH-1:0]        p0_rdata,
    input  logic                         p1_req,
    input  logic                         p1_we,
    input  logic [ADDR_WIDTH-1:0]        p1_addr,
    input  logic [DATA_WIDTH-1:0]        p1_wdata,
    input  logic [BYTES-1:0]             p1_wstrb,
    output logic                         p1_ack,
    output logic [DATA_WIDTH-1:0]        p1_rdata,
    output logic                         busy,
    output logic                         err_irq,
    input  logic                         err_clr,
    output logic [ADDR_WIDTH+BIDX_W-1:0] mem_a,
    output logic                         mem_rd,
    output logic                         mem_we,
    output logic                         mem_rend,
    output logic                         mem_wend,
    output logic [7:0]                   mem_din,
    input  logic [7:0]                   mem_dout,
    input  logic                         mem_byte_available,
    input  logic                         mem_ready_for_next_byte,
    input  logic                         mem_ready
);

    localparam int                 CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [BIDX_W-1:0]  IDX_LAST = BIDX_W'(BYTES - 1);

    logic [2:0]                   state_q;
    logic                         owner_q;
    logic                         rmw_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [DATA_WIDTH-1:0]        wdata_q;
    logic [BYTES-1:0]             wstrb_q;
    logic [BYTES-1:0][LANE_W-1:0] word_q;
    logic [BYTES-1:0][LANE_W-1:0] word_nxt;
    logic [BIDX_W-1:0]            idx_q;
    logic [CNT_W-1:0]             wait_q;
    logic                         ba_rise;
    logic                         rfnb_rise;

    logic                         sel_p1;
    logic                         g_valid;
    logic                         g_we;
    logic [ADDR_WIDTH-1:0]        g_addr;
    logic [DATA_WIDTH-1:0]        g_wdata;
    logic [BYTES-1:0]             g_wstrb;

    rise_detect u_ba_rise (
        .clk  (clk),
        .rst  (rst),
        .lvl  (mem_byte_available),
        .rise (ba_rise)
    );

    rise_detect u_rfnb_rise (
        .clk  (clk),
        .rst  (rst),
        .lvl  (mem_ready_for_next_byte),
        .rise (rfnb_rise)
    );

    // Fixed-priority grant: port 1 wins whenever it is requesting.
    always_comb begin
        sel_p1  = p1_req;
        g_valid = p0_req | p1_req;
        g_we    = sel_p1 ? p1_we    : p0_we;
        g_addr  = sel_p1 ? p1_addr  : p0_addr;
        g_wdata = sel_p1 ? p1_wdata : p0_wdata;
        g_wstrb = sel_p1 ? p1_wstrb : p0_wstrb;
    end

    // Next word buffer: full-write load, byte capture during reads, strobe merge.
    always_comb begin
        word_nxt = word_q;
        case (state_q)
            ST_IDLE:  if (g_valid && g_we) word_nxt = g_wdata;
            ST_RD:    if (ba_rise) word_nxt[idx_q] = mem_dout;
            ST_MERGE: begin
                for (int i = 0; i < BYTES; i++) begin
                    if (wstrb_q[i]) word_nxt[i] = wdata_q[LANE_W*i +: LANE_W];
                end
            end
            default:  word_nxt = word_q;
        endcase
    end

    // Data-path registers: word buffer and the latched write payload.
    always_ff @(posedge clk) begin
        word_q <= word_nxt;
        if (state_q == ST_IDLE && g_valid) begin
            wdata_q <= g_wdata;
            wstrb_q <= g_wstrb;
        end
    end

    // Control FSM, byte index, ready-timeout counter, strobes, rdata and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rmw_q    <= 1'b0;
            addr_q   <= '0;
            idx_q    <= '0;
            wait_q   <= '0;
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
            mem_rend <= 1'b0;
            mem_wend <= 1'b0;
            err_irq  <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
            mem_rend <= 1'b0;
            mem_wend <= 1'b0;
            if (err_clr) err_irq <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (g_valid) begin
                        owner_q <= sel_p1;
                        addr_q  <= g_addr;
                        idx_q   <= '0;
                        wait_q  <= '0;
                        rmw_q   <= 1'b0;
                        if (!g_we) begin
                            state_q <= ST_RD_WAIT;
                        end else if (&g_wstrb) begin
                            state_q <= ST_WR_WAIT;
                        end else if (|g_wstrb) begin
                            rmw_q   <= 1'b1;
                            state_q <= ST_RD_WAIT;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (mem_ready) begin
                        idx_q <= '0;
                        if (state_q == ST_RD_WAIT) begin
                            mem_rd  <= 1'b1;
                            state_q <= ST_RD;
                        end else begin
                            mem_we  <= 1'b1;
                            state_q <= ST_WR;
                        end
                    end else if (TIMEOUT != 0 && wait_q == CNT_LAST) begin
                        // Error wins over a same-cycle err_clr (assigned last).
                        err_irq <= 1'b1;
                        state_q <= ST_ERR;
                        if (owner_q) p1_rdata <= '1;
                        else         p0_rdata <= '1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end

                ST_RD: begin
                    if (ba_rise) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            mem_rend <= 1'b1;
                            if (rmw_q) begin
                                state_q <= ST_MERGE;
                            end else begin
                                state_q <= ST_DONE;
                                if (owner_q) p1_rdata <= word_nxt;
                                else         p0_rdata <= word_nxt;
                            end
                        end
                    end
                end

                ST_MERGE: begin
                    idx_q   <= '0;
                    wait_q  <= '0;
                    state_q <= ST_WR_WAIT;
                end

                ST_WR: begin
                    if (rfnb_rise) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            mem_wend <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Acks are high for exactly the single DONE/ERR cycle of the owning port.
    assign p0_ack  = (state_q == ST_DONE || state_q == ST_ERR) && !owner_q;
    assign p1_ack  = (state_q == ST_DONE || state_q == ST_ERR) &&  owner_q;
    assign busy    = (state_q != ST_IDLE);
    assign mem_a   = {addr_q, {BIDX_W{1'b0}}};
    assign mem_din = (state_q == ST_WR_WAIT || state_q == ST_WR) ? word_q[idx_q] : 8'h00;

endmodule

// File: tb/tb_psram_word_bridge.sv
// Bench for psram_word_bridge: byte-serial memory model, ack scoreboard,
// table-driven word operations and hand-written arbitration/timeout/reset cases.
module tb_psram_word_bridge;

    localparam int AW = 22;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int MW = AW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic [NB-1:0] p0_wstrb = '0, p1_wstrb = '0;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          busy, err_irq;
    logic          err_clr = 1'b0;
    logic [MW-1:0] mem_a;
    logic          mem_rd, mem_we, mem_rend, mem_wend;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout = 8'h00;
    logic          mem_byte_available = 1'b0;
    logic          mem_ready_for_next_byte = 1'b0;
    logic          mem_ready = 1'b1;

    psram_word_bridge #(.ADDR_WIDTH(AW), .BYTES(NB), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .busy(busy), .err_irq(err_irq), .err_clr(err_clr),
        .mem_a(mem_a), .mem_rd(mem_rd), .mem_we(mem_we), .mem_rend(mem_rend),
        .mem_wend(mem_wend), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_byte_available(mem_byte_available),
        .mem_ready_for_next_byte(mem_ready_for_next_byte), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic port; logic chk; logic [DW-1:0] data; } exp_t;
    typedef struct packed { logic port; logic [DW-1:0] data; } obs_t;
    exp_t sb_q[$];
    obs_t obs_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor-owned counters and captures.
    int            rd_cnt = 0, we_cnt = 0, rend_cnt = 0, wend_cnt = 0;
    logic [MW-1:0] last_a = '0;

    // Model-owned state.
    logic [7:0] mem [0:1023];
    logic [7:0] din_log[$];
    int         wr_bytes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Monitor: count memory strobes and record every ack as it happens.
    always @(negedge clk) begin
        if (mem_rd)   rd_cnt++;
        if (mem_we)   we_cnt++;
        if (mem_rend) rend_cnt++;
        if (mem_wend) wend_cnt++;
        if (mem_rd || mem_we) last_a = mem_a;
        if (p0_ack || p1_ack)
            obs_q.push_back('{port: p1_ack, data: (p1_ack ? p1_rdata : p0_rdata)});
    end

    // Byte-controller model: serves one word per mem_rd / mem_we start pulse.
    initial begin
        int base;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[16'h40] = 8'h11; mem[16'h41] = 8'h22; mem[16'h42] = 8'h33; mem[16'h43] = 8'h44;
        forever begin
            @(negedge clk);
            if (mem_rd && !rst) begin
                base = int'(mem_a) & 32'h3FF;
                for (int i = 0; i < NB; i++) begin
                    @(posedge clk); #1;
                    mem_dout = mem[base + i];
                    mem_byte_available = 1'b1;
                    @(negedge clk);
                    if (rst) break;
                    @(posedge clk); #1;
                    mem_byte_available = 1'b0;
                end
                mem_byte_available = 1'b0;
            end else if (mem_we && !rst) begin
                base = int'(mem_a) & 32'h3FF;
                for (int i = 0; i < NB; i++) begin
                    @(posedge clk); #1;
                    mem_ready_for_next_byte = 1'b1;
                    @(negedge clk);
                    if (rst) break;
                    din_log.push_back(mem_din);
                    mem[base + i] = mem_din;
                    wr_bytes++;
                    @(posedge clk); #1;
                    mem_ready_for_next_byte = 1'b0;
                end
                mem_ready_for_next_byte = 1'b0;
            end
        end
    end

    // Compare every observed ack against the expected queue, in order.
    task automatic drain();
        exp_t e;
        obs_t o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", {31'd0, o.port}, 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                chk("ack_port", {63'd0, o.port}, {63'd0, e.port});
                if (e.chk) chk("rdata", {32'd0, o.data}, {32'd0, e.data});
            end
        end
    endtask

    task automatic do_req(input logic port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NB-1:0] s, output int lat);
        lat = 0;
        @(posedge clk); #1;
        if (port) begin p1_we = we; p1_addr = a; p1_wdata = d; p1_wstrb = s; p1_req = 1'b1; end
        else      begin p0_we = we; p0_addr = a; p0_wdata = d; p0_wstrb = s; p0_req = 1'b1; end
        while (1) begin
            @(negedge clk);
            lat++;
            if (port ? p1_ack : p0_ack) break;
            if (lat > 300) begin chk("ack_wait", 64'd0, 64'd1); break; end
        end
        @(posedge clk); #1;
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        int b;
        b = (int'(a) * 4) & 32'h3FF;
        return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
    endfunction

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NB-1:0] wstrb;
        logic [DW-1:0] exp;
        int            n_rd;
        int            n_wr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lat, rd0, we0, rend0, wend0, d0;

        tbl[0] = '{1'b0, 1'b0, 22'h10, 32'h0,        4'h0,    32'h44332211, 1, 0};
        tbl[1] = '{1'b0, 1'b1, 22'h20, 32'hDEADBEEF, 4'hF,    32'hDEADBEEF, 0, 1};
        tbl[2] = '{1'b0, 1'b1, 22'h10, 32'hAABBCCDD, 4'b0101, 32'h44BB22DD, 1, 1};
        tbl[3] = '{1'b0, 1'b0, 22'h10, 32'h0,        4'h0,    32'h44BB22DD, 1, 0};
        tbl[4] = '{1'b0, 1'b1, 22'h30, 32'h12345678, 4'h0,    32'h00000000, 0, 0};
        tbl[5] = '{1'b0, 1'b0, 22'h20, 32'h0,        4'h0,    32'hDEADBEEF, 1, 0};
        tbl[6] = '{1'b0, 1'b1, 22'h10, 32'h99000000, 4'b1000, 32'h99BB22DD, 1, 1};
        tbl[7] = '{1'b1, 1'b0, 22'h10, 32'h0,        4'h0,    32'h99BB22DD, 1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_acks", {62'd0, p1_ack, p0_ack}, 64'd0);
        chk("rst_err", {63'd0, err_irq}, 64'd0);
        chk("rst_mem_ctl", {60'd0, mem_rd, mem_we, mem_rend, mem_wend}, 64'd0);
        chk("rst_mem_a", {40'd0, mem_a}, 64'd0);
        chk("rst_rdata", {p1_rdata, p0_rdata}, 64'd0);

        // Table-driven single operations
        for (int k = 0; k < 8; k++) begin
            rd0 = rd_cnt; we0 = we_cnt; rend0 = rend_cnt; wend0 = wend_cnt; d0 = din_log.size();
            sb_q.push_back('{port: tbl[k].port, chk: !tbl[k].we, data: tbl[k].exp});
            do_req(tbl[k].port, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].wstrb, lat);
            @(negedge clk);
            drain();
            chk("n_rd",   64'(rd_cnt - rd0),     64'(tbl[k].n_rd));
            chk("n_rend", 64'(rend_cnt - rend0), 64'(tbl[k].n_rd));
            chk("n_we",   64'(we_cnt - we0),     64'(tbl[k].n_wr));
            chk("n_wend", 64'(wend_cnt - wend0), 64'(tbl[k].n_wr));
            if (tbl[k].n_rd + tbl[k].n_wr > 0)
                chk("mem_a", {40'd0, last_a}, {40'd0, tbl[k].addr, 2'b00});
            if (tbl[k].we)
                chk("mem_word", {32'd0, mem_word(tbl[k].addr)}, {32'd0, tbl[k].exp});
            if (tbl[k].n_wr > 0) begin
                chk("din_count", 64'(din_log.size() - d0), 64'd4);
                for (int i = 0; i < NB && d0 + i < din_log.size(); i++)
                    chk("din_byte", {56'd0, din_log[d0 + i]}, {56'd0, tbl[k].exp[8*i +: 8]});
            end
            chk("idle_busy", {63'd0, busy}, 64'd0);
        end

        // Simultaneous requests: port 1 first, then port 0 with no lost request
        sb_q.push_back('{port: 1'b1, chk: 1'b1, data: 32'hDEADBEEF});
        sb_q.push_back('{port: 1'b0, chk: 1'b1, data: 32'h99BB22DD});
        fork
            begin int l1; do_req(1'b1, 1'b0, 22'h20, 32'h0, 4'h0, l1); end
            begin int l0; do_req(1'b0, 1'b0, 22'h10, 32'h0, 4'h0, l0); end
        join
        @(negedge clk);
        chk("arb_ack_count", 64'(obs_q.size()), 64'd2);
        drain();

        // Reset in the middle of a write burst
        wr_bytes = 0;
        @(posedge clk); #1;
        p0_we = 1'b1; p0_addr = 22'h40; p0_wdata = 32'hCAFEF00D; p0_wstrb = 4'hF; p0_req = 1'b1;
        lat = 0;
        while (wr_bytes < 2 && lat < 200) begin @(negedge clk); lat++; end
        chk("rst_wr_reached", {63'd0, (wr_bytes >= 2)}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; p0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mem_ctl", {60'd0, mem_rd, mem_we, mem_rend, mem_wend}, 64'd0);
        chk("midrst_mem_a_din", {32'd0, mem_a, mem_din}, 64'd0);
        chk("midrst_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_ack", 64'(obs_q.size()), 64'd0);
        sb_q.push_back('{port: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
        do_req(1'b0, 1'b0, 22'h20, 32'h0, 4'h0, lat);
        @(negedge clk);
        drain();

        // Ready timeout, error clear, and a strobe-less write
        mem_ready = 1'b0;
        rd0 = rd_cnt; we0 = we_cnt;
        sb_q.push_back('{port: 1'b0, chk: 1'b1, data: 32'hFFFFFFFF});
        do_req(1'b0, 1'b0, 22'h05, 32'h0, 4'h0, lat);
        @(negedge clk);
        drain();
        chk("to_latency", 64'(lat), 64'd18);
        chk("to_err_set", {63'd0, err_irq}, 64'd1);
        chk("to_no_rd", 64'(rd_cnt - rd0), 64'd0);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", {63'd0, err_irq}, 64'd0);
        sb_q.push_back('{port: 1'b0, chk: 1'b0, data: 32'h0});
        do_req(1'b0, 1'b1, 22'h30, 32'h55555555, 4'h0, lat);
        @(negedge clk);
        drain();
        chk("ws0_latency", 64'(lat), 64'd2);
        chk("ws0_no_mem", 64'((rd_cnt - rd0) + (we_cnt - we0)), 64'd0);
        chk("ws0_err", {63'd0, err_irq}, 64'd0);
        mem_ready = 1'b1;

        repeat (2) @(negedge clk);
        drain();
        chk("sb_pending", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
